// File: rtl/row_deskew_buffer_pkg.sv
// Constants shared by the FP16 scaling stage and the row deskew buffer, plus lane helpers.
package row_deskew_buffer_pkg;

  localparam int COL_NUM       = 32;
  localparam int DATA_W        = 16;
  localparam int FP16_W        = 16;
  localparam int FIFO_DEPTH    = 8;
  localparam int ROWS_PER_TILE = 32;

  // Row-index width; a one-row tile still needs a 1-bit field.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [FP16_W-1:0] lane_slice(input logic [COL_NUM*DATA_W-1:0] row,
                                                   input int lane);
    return row[lane*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/row_deskew_buffer_if.sv
// Aligned-row output stream: valid/ready handshake carrying row data, tile index and tile-last.
interface row_deskew_buffer_if #(
  parameter int COL_NUM       = row_deskew_buffer_pkg::COL_NUM,
  parameter int DATA_W        = row_deskew_buffer_pkg::DATA_W,
  parameter int ROWS_PER_TILE = row_deskew_buffer_pkg::ROWS_PER_TILE
);
  import row_deskew_buffer_pkg::idx_w;

  localparam int IDX_W = idx_w(ROWS_PER_TILE);

  logic [COL_NUM*DATA_W-1:0] row_out_data;
  logic                      row_out_valid;
  logic                      row_out_ready;
  logic [IDX_W-1:0]          row_out_idx;
  logic                      row_out_last;

  modport master (
    output row_out_data, row_out_valid, row_out_idx, row_out_last,
    input  row_out_ready
  );

  modport slave (
    input  row_out_data, row_out_valid, row_out_idx, row_out_last,
    output row_out_ready
  );

endinterface

// File: rtl/row_deskew_buffer_row_fifo.sv
// Single-clock FIFO with fall-through head; pointers carry a wrap bit so level covers 0..DEPTH.
module row_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             rd_ok;
  logic             wr_ok;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // A write into a full FIFO is only legal when the head leaves in the same cycle.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (wr_ok && !clear) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/row_deskew_buffer.sv
// Removes systolic wavefront skew (lane i lags lane 0 by i cycles) and queues aligned,
// index-tagged rows behind a valid/ready stream; rows that find the queue full are dropped.
module row_deskew_buffer #(
  parameter int COL_NUM       = row_deskew_buffer_pkg::COL_NUM,
  parameter int DATA_W        = row_deskew_buffer_pkg::DATA_W,
  parameter int FIFO_DEPTH    = row_deskew_buffer_pkg::FIFO_DEPTH,
  parameter int ROWS_PER_TILE = row_deskew_buffer_pkg::ROWS_PER_TILE
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic [COL_NUM*DATA_W-1:0]     in_data_diag,
  input  logic                          in_valid_diag,
  row_deskew_buffer_if.master           row_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);
  import row_deskew_buffer_pkg::idx_w;

  localparam int IDX_W = idx_w(ROWS_PER_TILE);
  localparam int ROW_W = COL_NUM*DATA_W;

  logic [ROW_W-1:0]   aligned_data;
  logic [COL_NUM-2:0] vld_pipe;
  logic               aligned_valid;
  logic [IDX_W-1:0]   row_cnt;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_wr;
  logic               fifo_rd;
  logic               drop;
  logic [IDX_W-1:0]   head_idx;

  // Lane i waits COL_NUM-1-i cycles so every lane lines up with the last one.
  for (genvar i = 0; i < COL_NUM; i++) begin : g_lane
    localparam int D = COL_NUM - 1 - i;
    if (D == 0) begin : g_direct
      assign aligned_data[i*DATA_W +: DATA_W] = in_data_diag[i*DATA_W +: DATA_W];
    end else begin : g_dly
      logic [DATA_W-1:0] dly_p [D];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < D; k++) dly_p[k] <= '0;
        end else begin
          dly_p[0] <= in_data_diag[i*DATA_W +: DATA_W];
          for (int k = 1; k < D; k++) dly_p[k] <= dly_p[k-1];
        end
      end
      assign aligned_data[i*DATA_W +: DATA_W] = dly_p[D-1];
    end
  end

  // Valid follows lane 0 through the full COL_NUM-1 stage delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     vld_pipe <= '0;
    else if (clear) vld_pipe <= '0;
    else            vld_pipe <= {vld_pipe[COL_NUM-3:0], in_valid_diag};
  end

  assign aligned_valid = vld_pipe[COL_NUM-2];

  assign fifo_rd = row_out.row_out_valid && row_out.row_out_ready;
  assign fifo_wr = aligned_valid && !clear && (!fifo_full || fifo_rd);
  assign drop    = aligned_valid && !clear && fifo_full && !fifo_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt  <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      row_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (fifo_wr) begin
        row_cnt <= (row_cnt == IDX_W'(ROWS_PER_TILE-1)) ? '0 : row_cnt + IDX_W'(1);
      end
      if (drop) overflow <= 1'b1;
    end
  end

  row_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ROW_W + IDX_W)
  ) u_row_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .wr_en   (fifo_wr),
    .wr_data ({row_cnt, aligned_data}),
    .full    (fifo_full),
    .rd_en   (fifo_rd),
    .rd_data ({head_idx, row_out.row_out_data}),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign row_out.row_out_valid = !fifo_empty;
  assign row_out.row_out_idx   = head_idx;
  assign row_out.row_out_last  = (head_idx == IDX_W'(ROWS_PER_TILE-1));

endmodule
